// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU select codes,
// instruction classes, FSM state encoding and the strobe bundle.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,  ALU_AND = 4'd3,
    ALU_OR   = 4'd4, ALU_SHR = 4'd5, ALU_SHRA = 4'd6, ALU_SHL = 4'd7,
    ALU_ROR  = 4'd8, ALU_ROL = 4'd9, ALU_MUL = 4'd10, ALU_DIV = 4'd11,
    ALU_NEG  = 4'd12, ALU_NOT = 4'd13
  } alu_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_IMM, CL_UNARY, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
    CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
  } cls_e;

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_e;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, wren;
    logic ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic c_out, con_in, inport_out, outport_en;
    logic lo_in, lo_out, hi_in, hi_out;
    alu_e ctrl;
    logic run;
  } strobes_t;

  // Final step of each instruction class; the FSM returns to T0 after it.
  function automatic state_e last_step(input cls_e c);
    state_e s;
    case (c)
      CL_ALU, CL_IMM, CL_LDI: s = S_T5;
      CL_UNARY, CL_JAL:       s = S_T4;
      CL_LD, CL_ST:           s = S_T7;
      CL_MULDIV, CL_BR:       s = S_T6;
      default:                s = S_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_opcode_decode.sv
// Combinational opcode decode: instruction class plus the ALU select the
// class will drive during its ALU step.
module opcode_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output cls_e       cls,
  output alu_e       alu
);

  always_comb begin
    cls = CL_NOP;
    alu = ALU_NONE;
    case (opcode)
      OP_LD:   begin cls = CL_LD;     alu = ALU_ADD;  end
      OP_LDI:  begin cls = CL_LDI;    alu = ALU_ADD;  end
      OP_ST:   begin cls = CL_ST;     alu = ALU_ADD;  end
      OP_ADD:  begin cls = CL_ALU;    alu = ALU_ADD;  end
      OP_SUB:  begin cls = CL_ALU;    alu = ALU_SUB;  end
      OP_AND:  begin cls = CL_ALU;    alu = ALU_AND;  end
      OP_OR:   begin cls = CL_ALU;    alu = ALU_OR;   end
      OP_SHR:  begin cls = CL_ALU;    alu = ALU_SHR;  end
      OP_SHRA: begin cls = CL_ALU;    alu = ALU_SHRA; end
      OP_SHL:  begin cls = CL_ALU;    alu = ALU_SHL;  end
      OP_ROR:  begin cls = CL_ALU;    alu = ALU_ROR;  end
      OP_ROL:  begin cls = CL_ALU;    alu = ALU_ROL;  end
      OP_ADDI: begin cls = CL_IMM;    alu = ALU_ADD;  end
      OP_ANDI: begin cls = CL_IMM;    alu = ALU_AND;  end
      OP_ORI:  begin cls = CL_IMM;    alu = ALU_OR;   end
      OP_MUL:  begin cls = CL_MULDIV; alu = ALU_MUL;  end
      OP_DIV:  begin cls = CL_MULDIV; alu = ALU_DIV;  end
      OP_NEG:  begin cls = CL_UNARY;  alu = ALU_NEG;  end
      OP_NOT:  begin cls = CL_UNARY;  alu = ALU_NOT;  end
      OP_BR:   begin cls = CL_BR;     alu = ALU_ADD;  end
      OP_JR:   cls = CL_JR;
      OP_JAL:  cls = CL_JAL;
      OP_IN:   cls = CL_IN;
      OP_OUT:  cls = CL_OUT;
      OP_MFHI: cls = CL_MFHI;
      OP_MFLO: cls = CL_MFLO;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch T0-T2, class-specific steps T3-T7, HALT.
// All strobes decode from registered state (step, class, ALU op, branch take).
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout, PCin, IncPC,
  output logic        MARin, MDRin, MDRout, Read, wren,
  output logic        IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Cout, conInput, InPortout, outPortEnable,
  output logic        LOin, LOout, HIin, HIout,
  output logic [3:0]  ctrl,
  output logic        Run
);

  state_e   state, state_nxt;
  cls_e     cls_q, dec_cls;
  alu_e     op_q, dec_alu;
  logic     take_q;
  strobes_t s;
  logic     unused_ir;

  assign unused_ir = ^IR[26:0];

  opcode_decode u_dec (.opcode(IR[31:27]), .cls(dec_cls), .alu(dec_alu));

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state  <= S_RESET;
      cls_q  <= CL_NOP;
      op_q   <= ALU_NONE;
      take_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) begin
        cls_q <= dec_cls;
        op_q  <= dec_alu;
      end
      // Branch decision is frozen on the edge entering T6.
      if (state == S_T5) take_q <= CON;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (cls_q == CL_HALT)                 state_nxt = S_HALT;
        else if (state == last_step(cls_q))   state_nxt = S_T0;
        else                                  state_nxt = state_e'(state + 4'd1);
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    s     = '0;
    s.run = (state != S_HALT);
    case (state)
      S_T0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.zlow_in = 1'b1; end
      S_T1: begin s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1; end
      S_T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      S_T3: case (cls_q)
        CL_ALU, CL_IMM:      begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
        CL_UNARY:            begin s.grb = 1'b1; s.r_out = 1'b1; s.ctrl = op_q; s.zlow_in = 1'b1; end
        CL_LDI, CL_LD, CL_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
        CL_MULDIV:           begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
        CL_BR:               begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
        CL_JR:               begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
        CL_JAL:              begin s.pc_out = 1'b1; s.grb = 1'b1; s.r_in = 1'b1; end
        CL_IN:               begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        CL_OUT:              begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_en = 1'b1; end
        CL_MFHI:             begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        CL_MFLO:             begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls_q)
        CL_ALU:              begin s.grc = 1'b1; s.r_out = 1'b1; s.ctrl = op_q; s.zlow_in = 1'b1; end
        CL_IMM, CL_LDI, CL_LD, CL_ST:
                             begin s.c_out = 1'b1; s.ctrl = op_q; s.zlow_in = 1'b1; end
        CL_UNARY:            begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        CL_MULDIV:           begin s.grb = 1'b1; s.r_out = 1'b1; s.ctrl = op_q;
                                   s.zlow_in = 1'b1; s.zhigh_in = 1'b1; end
        CL_BR:               begin s.pc_out = 1'b1; s.y_in = 1'b1; end
        CL_JAL:              begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls_q)
        CL_ALU, CL_IMM, CL_LDI: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        CL_LD, CL_ST:        begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
        CL_MULDIV:           begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
        CL_BR:               begin s.c_out = 1'b1; s.ctrl = op_q; s.zlow_in = 1'b1; end
        default: ;
      endcase
      S_T6: case (cls_q)
        CL_LD:               begin s.read = 1'b1; s.mdr_in = 1'b1; end
        CL_ST:               begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
        CL_MULDIV:           begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
        CL_BR:               begin s.zlow_out = take_q; s.pc_in = take_q; end
        default: ;
      endcase
      S_T7: case (cls_q)
        CL_LD:               begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
        CL_ST:               s.wren = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign PCout = s.pc_out;        assign PCin = s.pc_in;         assign IncPC = s.inc_pc;
  assign MARin = s.mar_in;        assign MDRin = s.mdr_in;       assign MDRout = s.mdr_out;
  assign Read = s.read;           assign wren = s.wren;          assign IRin = s.ir_in;
  assign Yin = s.y_in;            assign Zlowin = s.zlow_in;     assign Zhighin = s.zhigh_in;
  assign Zlowout = s.zlow_out;    assign Zhighout = s.zhigh_out; assign Gra = s.gra;
  assign Grb = s.grb;             assign Grc = s.grc;            assign Rin = s.r_in;
  assign Rout = s.r_out;          assign BAout = s.ba_out;       assign Cout = s.c_out;
  assign conInput = s.con_in;     assign InPortout = s.inport_out;
  assign outPortEnable = s.outport_en;
  assign LOin = s.lo_in;          assign LOout = s.lo_out;       assign HIin = s.hi_in;
  assign HIout = s.hi_out;        assign ctrl = s.ctrl;          assign Run = s.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle strobe sequences from an instruction-level
// table model, directed cases plus a random instruction stream.
module tb_control_unit;
  import control_unit_pkg::*;

  typedef logic [32:0] vec_t;
  localparam vec_t PCOUT = 33'd1 << 0,  PCIN = 33'd1 << 1,   INCPC = 33'd1 << 2;
  localparam vec_t MARIN = 33'd1 << 3,  MDRIN = 33'd1 << 4,  MDROUT = 33'd1 << 5;
  localparam vec_t READ = 33'd1 << 6,   WREN = 33'd1 << 7,   IRIN = 33'd1 << 8;
  localparam vec_t YIN = 33'd1 << 9,    ZLOWIN = 33'd1 << 10, ZHIGHIN = 33'd1 << 11;
  localparam vec_t ZLOWOUT = 33'd1 << 12, ZHIGHOUT = 33'd1 << 13;
  localparam vec_t GRA = 33'd1 << 14,   GRB = 33'd1 << 15,   GRC = 33'd1 << 16;
  localparam vec_t RIN = 33'd1 << 17,   ROUT = 33'd1 << 18,  BAOUT = 33'd1 << 19;
  localparam vec_t COUT = 33'd1 << 20,  CONIN = 33'd1 << 21, INPORTOUT = 33'd1 << 22;
  localparam vec_t OUTPORTEN = 33'd1 << 23, LOIN = 33'd1 << 24, LOOUT = 33'd1 << 25;
  localparam vec_t HIIN = 33'd1 << 26,  HIOUT = 33'd1 << 27, RUN = 33'd1 << 32;

  logic        Clock, Clear, CON;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, wren;
  logic IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, conInput, InPortout, outPortEnable;
  logic LOin, LOout, HIin, HIout, Run;
  logic [3:0] ctrl;
  vec_t obs;

  int   errors = 0, checks = 0;
  vec_t exp_q[$];
  bit   watch_lohi = 0;
  int   lohi_hits = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .wren(wren),
    .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .conInput(conInput), .InPortout(InPortout), .outPortEnable(outPortEnable),
    .LOin(LOin), .LOout(LOout), .HIin(HIin), .HIout(HIout),
    .ctrl(ctrl), .Run(Run)
  );

  assign obs = {Run, ctrl, HIout, HIin, LOout, LOin, outPortEnable, InPortout, conInput,
                Cout, BAout, Rout, Rin, Grc, Grb, Gra, Zhighout, Zlowout, Zhighin,
                Zlowin, Yin, IRin, wren, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(negedge Clock) if (watch_lohi && (LOin || HIin)) lohi_hits++;

  function automatic vec_t ct(input alu_e a);
    return vec_t'(a) << 28;
  endfunction

  function automatic vec_t op_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ct(ALU_ADD);
      OP_SUB:          return ct(ALU_SUB);
      OP_AND, OP_ANDI: return ct(ALU_AND);
      OP_OR, OP_ORI:   return ct(ALU_OR);
      OP_SHR:          return ct(ALU_SHR);
      OP_SHRA:         return ct(ALU_SHRA);
      OP_SHL:          return ct(ALU_SHL);
      OP_ROR:          return ct(ALU_ROR);
      OP_ROL:          return ct(ALU_ROL);
      OP_MUL:          return ct(ALU_MUL);
      OP_DIV:          return ct(ALU_DIV);
      OP_NEG:          return ct(ALU_NEG);
      OP_NOT:          return ct(ALU_NOT);
      default:         return '0;
    endcase
  endfunction

  function automatic void push(input vec_t v);
    exp_q.push_back(v | RUN);
  endfunction

  // Expected per-cycle outputs of one instruction, T0 through its last step.
  function automatic void build(input logic [4:0] op, input bit con);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZLOWIN);
    push(ZLOWOUT | PCIN | READ | MDRIN);
    push(MDROUT | IRIN);
    if (op >= OP_ADD && op <= OP_ROL) begin
      push(GRB | ROUT | YIN); push(GRC | ROUT | ZLOWIN | op_alu(op)); push(ZLOWOUT | GRA | RIN);
    end else if (op >= OP_ADDI && op <= OP_ORI) begin
      push(GRB | ROUT | YIN); push(COUT | ZLOWIN | op_alu(op)); push(ZLOWOUT | GRA | RIN);
    end else if (op == OP_NEG || op == OP_NOT) begin
      push(GRB | ROUT | ZLOWIN | op_alu(op)); push(ZLOWOUT | GRA | RIN);
    end else if (op == OP_LDI || op == OP_LD || op == OP_ST) begin
      push(GRB | BAOUT | YIN); push(COUT | ZLOWIN | ct(ALU_ADD));
      if (op == OP_LDI) push(ZLOWOUT | GRA | RIN);
      else begin
        push(ZLOWOUT | MARIN);
        if (op == OP_LD) begin push(READ | MDRIN); push(MDROUT | GRA | RIN); end
        else begin push(GRA | ROUT | MDRIN); push(WREN); end
      end
    end else if (op == OP_MUL || op == OP_DIV) begin
      push(GRA | ROUT | YIN); push(GRB | ROUT | ZLOWIN | ZHIGHIN | op_alu(op));
      push(ZLOWOUT | LOIN); push(ZHIGHOUT | HIIN);
    end else if (op == OP_BR) begin
      push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ZLOWIN | ct(ALU_ADD));
      push(con ? (ZLOWOUT | PCIN) : '0);
    end else if (op == OP_JR)   push(GRA | ROUT | PCIN);
    else if (op == OP_JAL) begin push(PCOUT | GRB | RIN); push(GRA | ROUT | PCIN); end
    else if (op == OP_IN)   push(INPORTOUT | GRA | RIN);
    else if (op == OP_OUT)  push(GRA | ROUT | OUTPORTEN);
    else if (op == OP_MFHI) push(HIOUT | GRA | RIN);
    else if (op == OP_MFLO) push(LOOUT | GRA | RIN);
    else if (op == OP_HALT) begin
      push('0);
      repeat (20) exp_q.push_back('0);
    end else push('0);
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Entered at the negedge inside T0; full runs leave at the next T0 negedge.
  task automatic run_instr(input logic [31:0] ir, input bit con, input int n);
    int len;
    IR  = ir;
    CON = con;
    build(ir[31:27], con);
    len = (n > 0 && n < exp_q.size()) ? n : exp_q.size();
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge Clock);
      check($sformatf("op%0d_t%0d", ir[31:27], k), obs, exp_q[k]);
    end
    if (n <= 0) @(negedge Clock);
  endtask

  initial begin
    logic [4:0] op;
    Clear = 1'b0;
    IR    = '0;
    CON   = 1'b0;
    #3 check("reset_async", obs, RUN);
    repeat (2) @(negedge Clock);
    check("reset_held", obs, RUN);
    Clear = 1'b1;
    @(negedge Clock);

    run_instr(32'h1800_0000, 1'b0, 0);           // add
    run_instr(32'h0080_0005, 1'b0, 0);           // ld
    run_instr({OP_BR, 27'h0400123}, 1'b1, 0);    // br taken
    run_instr({OP_BR, 27'h0400123}, 1'b0, 0);    // br not taken
    run_instr(32'hA080_0000, 1'b0, 0);           // jr
    run_instr({OP_ST, 27'h0}, 1'b0, 0);
    run_instr({5'd30, 27'h0}, 1'b0, 0);          // undefined opcode

    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HALT) op = OP_NOP;
      run_instr({op, 27'($urandom)}, 1'($urandom), 0);
    end

    // Abort mul at T4, then resume with a complete add.
    watch_lohi = 1'b1;
    run_instr({OP_MUL, 27'h0}, 1'b0, 5);
    Clear = 1'b0;
    #1 check("abort_async", obs, RUN);
    @(negedge Clock);
    check("abort_held", obs, RUN);
    Clear = 1'b1;
    @(negedge Clock);
    run_instr(32'h1800_0000, 1'b0, 0);
    watch_lohi = 1'b0;
    check("abort_no_lohi", vec_t'(lohi_hits), '0);

    // halt: Run low for 20 cycles, then a Clear pulse restarts fetch.
    run_instr({OP_HALT, 27'h0}, 1'b0, 0);
    check("halt_held", obs, '0);
    Clear = 1'b0;
    #1 check("halt_clear", obs, RUN);
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    run_instr({OP_NOP, 27'h0}, 1'b0, 0);
    check("final_t0", obs, RUN | PCOUT | MARIN | INCPC | ZLOWIN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
